// File: rtl/if_fetch_unit_pkg.sv
// Shared encodings and types for the instruction-fetch stage.
package if_fetch_unit_pkg;

  // Memory-controller request op encodings
  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_SAVE = 2'b10;

  // Memory-controller request length encodings
  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Fetch control states: FLUSH lasts one cycle after every redirect
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

  // One queue entry: instruction word tagged with its PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

endpackage

// File: rtl/if_inst_queue.sv
// Small synchronous instruction FIFO with flush and registered head outputs.
// The head registers always mirror the entry at the next head pointer, so
// the outputs carry no combinational path from push data.
module if_inst_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic        full,
  output logic        empty,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  inst_entry_t   mem_r [QDEPTH];
  logic [AW-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
  logic [CW-1:0] count_r, count_nxt_s;
  logic          pop_s, push_s;
  inst_entry_t   push_entry_s, head_data_nxt_s, head_data_r;
  logic          head_valid_r;

  assign full         = (count_r == DEPTH_C);
  assign empty        = (count_r == '0);
  assign head_valid   = head_valid_r;
  assign head_pc      = head_data_r.pc;
  assign head_inst    = head_data_r.inst;
  assign push_entry_s = '{pc: push_pc, inst: push_inst};

  // Next pointers/count; flush overrides any push or pop in the same cycle
  always_comb begin
    pop_s           = pop & ~empty & ~flush;
    push_s          = push & ~flush & (~full | pop_s);
    head_nxt_s      = head_r;
    tail_nxt_s      = tail_r;
    count_nxt_s     = count_r;
    if (flush) begin
      head_nxt_s  = '0;
      tail_nxt_s  = '0;
      count_nxt_s = '0;
    end else begin
      if (pop_s) begin
        head_nxt_s = head_r + AW'(1'b1);
      end else begin
        head_nxt_s = head_r;
      end
      if (push_s) begin
        tail_nxt_s = tail_r + AW'(1'b1);
      end else begin
        tail_nxt_s = tail_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1'b1);
        2'b01:   count_nxt_s = count_r - CW'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
    // A push landing in the slot that becomes head must bypass into the head regs
    if (push_s && (tail_r == head_nxt_s)) begin
      head_data_nxt_s = push_entry_s;
    end else begin
      head_data_nxt_s = mem_r[head_nxt_s];
    end
  end

  // Storage, pointers and registered head outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_r[i] <= '0;
      end
      head_r       <= '0;
      tail_r       <= '0;
      count_r      <= '0;
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[tail_r] <= push_entry_s;
      end
      head_r       <= head_nxt_s;
      tail_r       <= tail_nxt_s;
      count_r      <= count_nxt_s;
      head_valid_r <= (count_nxt_s != '0);
      head_data_r  <= head_data_nxt_s;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, qualifies controller responses
// on their rising edge, queues fetched words toward decode and handles redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        jmp_in,
  input  logic [31:0] jmp_target,
  output logic [1:0]  IF_op,
  output logic [1:0]  IF_len,
  output logic [31:0] IF_addr,
  input  logic        IF_rdy,
  input  logic [31:0] IF_out,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  fetch_state_e state_r, state_nxt_s;
  logic [31:0]  fetch_pc_r;
  logic         rdy_q_r;
  logic         redirect_s, pop_s, accept_s;
  logic         q_full_s, q_empty_s;

  assign IF_op   = MEM_LOAD;
  assign IF_len  = MEM_WORD;
  assign IF_addr = fetch_pc_r;

  // Redirect, pop and response-accept qualification plus next control state
  always_comb begin
    redirect_s = rdy_in & jmp_in;
    pop_s      = rdy_in & ~q_empty_s & id_ready & ~jmp_in;
    accept_s   = rdy_in & IF_rdy & ~rdy_q_r & ~jmp_in & (state_r == ST_RUN)
               & (~q_full_s | pop_s);
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN, ST_FLUSH: begin
        if (redirect_s) begin
          state_nxt_s = ST_FLUSH;
        end else if (rdy_in) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Control state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC: moves only on redirect or accepted word so IF_addr stays stable
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_pc_r <= RESET_PC;
    end else if (redirect_s) begin
      fetch_pc_r <= jmp_target & 32'hFFFF_FFFC;
    end else if (accept_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Delayed IF_rdy for rising-edge detection, frozen while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q_r <= 1'b0;
    end else if (rdy_in) begin
      rdy_q_r <= IF_rdy;
    end else begin
      rdy_q_r <= rdy_q_r;
    end
  end

  if_inst_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .push       (accept_s),
    .pop        (pop_s),
    .flush      (redirect_s),
    .push_pc    (fetch_pc_r),
    .push_inst  (IF_out),
    .full       (q_full_s),
    .empty      (q_empty_s),
    .head_valid (inst_valid),
    .head_pc    (inst_pc),
    .head_inst  (inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        jmp_in;
  logic [31:0] jmp_target;
  logic [1:0]  IF_op;
  logic [1:0]  IF_len;
  logic [31:0] IF_addr;
  logic        IF_rdy;
  logic [31:0] IF_out;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  if_fetch_unit dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .jmp_in     (jmp_in),
    .jmp_target (jmp_target),
    .IF_op      (IF_op),
    .IF_len     (IF_len),
    .IF_addr    (IF_addr),
    .IF_rdy     (IF_rdy),
    .IF_out     (IF_out),
    .id_ready   (id_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] i, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, inst_valid}, {31'd0, v});
    check({tag, "_inst"}, inst, i);
    check({tag, "_pc"}, inst_pc, pc);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; jmp_in = 1'b0; jmp_target = 32'h0;
    IF_rdy = 1'b0; IF_out = 32'h0; id_ready = 1'b1;
    tick(); tick();
    // reset state
    head("rst", 1'b0, 32'h0, 32'h0);
    check("rst_addr", IF_addr, 32'h0);
    check("rst_op", {30'd0, IF_op}, {30'd0, MEM_LOAD});
    check("rst_len", {30'd0, IF_len}, {30'd0, MEM_WORD});
    rst_n_in = 1'b1;
    tick();

    // first fetch at PC 0
    IF_rdy = 1'b1; IF_out = 32'h0000_0013; tick();
    head("t1", 1'b1, 32'h13, 32'h0);
    check("t1_addr", IF_addr, 32'h4);
    IF_rdy = 1'b0; tick();
    check("t1_pop_valid", {31'd0, inst_valid}, 32'd0);

    // fresh start for the backpressure test
    rst_n_in = 1'b0; #1; rst_n_in = 1'b1;
    check("rst2_addr", IF_addr, 32'h0);
    id_ready = 1'b0;
    IF_rdy = 1'b1; IF_out = 32'hAAAA_0001; tick(); IF_rdy = 1'b0; tick();
    head("a", 1'b1, 32'hAAAA_0001, 32'h0);
    check("a_addr", IF_addr, 32'h4);
    IF_rdy = 1'b1; IF_out = 32'hBBBB_0002; tick(); IF_rdy = 1'b0; tick();
    check("b_addr", IF_addr, 32'h8);
    IF_rdy = 1'b1; IF_out = 32'hCCCC_0003; tick();
    check("c_drop_addr", IF_addr, 32'h8);
    head("c_drop", 1'b1, 32'hAAAA_0001, 32'h0);
    IF_rdy = 1'b0; id_ready = 1'b1; tick();
    head("pop_a", 1'b1, 32'hBBBB_0002, 32'h4);
    id_ready = 1'b0; IF_rdy = 1'b1; IF_out = 32'hCCCC_0003; tick();
    check("c_refetch_addr", IF_addr, 32'hC);
    IF_rdy = 1'b0; id_ready = 1'b1; tick();
    head("c_head", 1'b1, 32'hCCCC_0003, 32'h8);
    id_ready = 1'b0; IF_rdy = 1'b1; IF_out = 32'hDDDD_0004; tick(); IF_rdy = 1'b0; tick();
    check("d_addr", IF_addr, 32'h10);

    // redirect with a simultaneous response and two queued entries
    jmp_in = 1'b1; jmp_target = 32'h0000_1003; IF_rdy = 1'b1; IF_out = 32'hDEAD_BEEF; tick();
    check("jmp_valid", {31'd0, inst_valid}, 32'd0);
    check("jmp_addr", IF_addr, 32'h1000);
    jmp_in = 1'b0; tick();
    check("stale1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    check("stale2_valid", {31'd0, inst_valid}, 32'd0);
    check("stale2_addr", IF_addr, 32'h1000);
    IF_rdy = 1'b0; tick();
    IF_rdy = 1'b1; IF_out = 32'hEEEE_0005; tick();
    head("e", 1'b1, 32'hEEEE_0005, 32'h1000);
    check("e_addr", IF_addr, 32'h1004);
    IF_rdy = 1'b0; tick();

    // freeze: response, jump and pop all held off
    rdy_in = 1'b0; IF_rdy = 1'b1; IF_out = 32'hFFFF_0006;
    jmp_in = 1'b1; jmp_target = 32'h0000_2000; id_ready = 1'b1;
    tick(); tick();
    head("frz", 1'b1, 32'hEEEE_0005, 32'h1000);
    check("frz_addr", IF_addr, 32'h1004);
    rdy_in = 1'b1; tick();
    check("unfrz_valid", {31'd0, inst_valid}, 32'd0);
    check("unfrz_addr", IF_addr, 32'h2000);
    jmp_in = 1'b0; IF_rdy = 1'b0; tick(); tick();

    // fresh IF_rdy edge during FLUSH must be ignored
    jmp_in = 1'b1; jmp_target = 32'h0000_3000; tick();
    jmp_in = 1'b0; IF_rdy = 1'b1; IF_out = 32'hBAD0_0BAD; tick();
    check("flush_ign_valid", {31'd0, inst_valid}, 32'd0);
    check("flush_ign_addr", IF_addr, 32'h3000);
    IF_rdy = 1'b0; tick();

    // fill, then push and pop together while full
    id_ready = 1'b0;
    IF_rdy = 1'b1; IF_out = 32'h6666_0007; tick(); IF_rdy = 1'b0; tick();
    IF_rdy = 1'b1; IF_out = 32'h7777_0008; tick(); IF_rdy = 1'b0; tick();
    head("full", 1'b1, 32'h6666_0007, 32'h3000);
    check("full_addr", IF_addr, 32'h3008);
    id_ready = 1'b1; IF_rdy = 1'b1; IF_out = 32'h8888_0009; tick();
    head("pushpop", 1'b1, 32'h7777_0008, 32'h3004);
    check("pushpop_addr", IF_addr, 32'h300C);
    id_ready = 1'b0; IF_rdy = 1'b0; tick();
    head("hold", 1'b1, 32'h7777_0008, 32'h3004);
    id_ready = 1'b1; tick();
    head("pop_h", 1'b1, 32'h8888_0009, 32'h3008);
    id_ready = 1'b0; tick();

    // asynchronous reset mid-stream
    rst_n_in = 1'b0; #1;
    head("arst", 1'b0, 32'h0, 32'h0);
    check("arst_addr", IF_addr, 32'h0);
    check("arst_op", {30'd0, IF_op}, {30'd0, MEM_LOAD});
    check("arst_len", {30'd0, IF_len}, {30'd0, MEM_WORD});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
